muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide engine for the EXE stage; the next generation of the EXE-stage mult/div path.
- Replaces vendor multiplier/divider IP with an iterative radix-2 restoring divider and a latency-programmable multiplier.
- Uses a start/busy/done handshake with a pipeline-flush cancel.
- Produces HI/LO results for the MEM-stage write of the HI/LO registers.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_if.sv | 30 +++
 rtl/div_step.sv | 20 ++
 rtl/muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_muldiv_unit.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and decode helper for the EXE-stage mult/div unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MSUB  = 3'b110;
  localparam logic [2:0] OP_MSUBU = 3'b111;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  function automatic logic is_div(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Start/busy/done request bus between the EXE stage and the mult/div unit.
interface muldiv_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
);
  logic             start;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div0;

  modport master (
    output start, op, src1, src2,
    output acc_hi, acc_lo, cancel,
    input  busy, done, hi, lo, div0
  );

  modport slave (
    input  start, op, src1, src2,
    input  acc_hi, acc_lo, cancel,
    output busy, done, hi, lo, div0
  );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on a magnitude dividend/divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);
  logic [WIDTH:0] r2;
  logic [WIDTH:0] diff;
  logic           ok;

  assign r2    = {rem, quo[WIDTH-1]};
  assign diff  = r2 - {1'b0, dvs};
  assign ok    = ~diff[WIDTH];
  assign rem_n = ok ? diff[WIDTH-1:0] : r2[WIDTH-1:0];
  assign quo_n = {quo[WIDTH-2:0], ok};
endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine for EXE; HI/LO out to MEM.
// MULDIV_MADD_EN enables the MADD/MSUB accumulate ops.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2,
  parameter int OPW     = 3
) (
  input logic  clk,
  input logic  reset,
  muldiv_if.slave m
);
  localparam int CW = $clog2(WIDTH);

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic             sgn_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] rem_n, quo_n;
  logic             qneg_q, rneg_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             div0_q;

  logic             accept, sgn_in, an, bn;
  logic [WIDTH-1:0] amag, bmag;
  logic [2*WIDTH-1:0] sa, sb, prod, res;
  logic [WIDTH-1:0] qf, rf;

  assign accept = m.start & ~m.cancel &
                  (state == S_IDLE | state == S_DONE);
  assign sgn_in = ~m.op[0];
  assign an     = sgn_in & m.src1[WIDTH-1];
  assign bn     = sgn_in & m.src2[WIDTH-1];
  assign amag   = an ? -m.src1 : m.src1;
  assign bmag   = bn ? -m.src2 : m.src2;

  // Sign-extend to 2W so the low 2W product bits match a signed multiply.
  assign sa   = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign sb   = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
  assign prod = sa * sb;

`ifdef MULDIV_MADD_EN
  logic               acc_en_q, sub_q;
  logic [2*WIDTH-1:0] acc_q;
  assign res = !acc_en_q ? prod :
               sub_q ? acc_q - prod : acc_q + prod;
`else
  logic unused_acc;
  assign unused_acc = ^{m.acc_hi, m.acc_lo};
  assign res = prod;
`endif

  assign qf = qneg_q ? -quo : quo;
  assign rf = rneg_q ? -rem : rem;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem   (rem),
    .quo   (quo),
    .dvs   (dvs),
    .rem_n (rem_n),
    .quo_n (quo_n)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      sgn_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      div0_q <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_en_q <= 1'b0;
      sub_q    <= 1'b0;
      acc_q    <= '0;
`endif
    end else if (m.cancel) begin
      state <= S_IDLE;
    end else if (accept) begin
      sgn_q  <= sgn_in;
      a_q    <= m.src1;
      b_q    <= m.src2;
      div0_q <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_en_q <= m.op[2];
      sub_q    <= m.op[1];
      acc_q    <= {m.acc_hi, m.acc_lo};
`endif
      if (is_div(m.op[2:0])) begin
        state  <= S_DIV;
        cnt    <= CW'(WIDTH - 1);
        rem    <= '0;
        quo    <= amag;
        dvs    <= bmag;
        qneg_q <= an ^ bn;
        rneg_q <= an;
        dz_q   <= (m.src2 == '0);
      end else begin
        state <= S_MUL;
        cnt   <= CW'(MUL_LAT - 1);
      end
    end else begin
      unique case (1'b1)
        state == S_MUL: begin
          if (cnt == '0) begin
            {hi_q, lo_q} <= res;
            state        <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        state == S_DIV: begin
          rem <= rem_n;
          quo <= quo_n;
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        state == S_FIX: begin
          lo_q   <= dz_q ? '1 : qf;
          hi_q   <= dz_q ? a_q : rf;
          div0_q <= dz_q;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign m.busy = (state == S_MUL) | (state == S_DIV) | (state == S_FIX);
  assign m.done = (state == S_DONE);
  assign m.hi   = hi_q;
  assign m.lo   = lo_q;
  assign m.div0 = div0_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, div0, cancel, back-to-back.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32), .OPW(3)) bus ();

  muldiv_unit #(.WIDTH(32), .MUL_LAT(2), .OPW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .m     (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ah, input logic [31:0] al,
                     input int lat, input logic [31:0] eh,
                     input logic [31:0] el, input logic ed);
    int n;
    @(negedge clk);
    bus.op = op; bus.src1 = a; bus.src2 = b;
    bus.acc_hi = ah; bus.acc_lo = al;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.src1 = 32'hDEAD_BEEF; bus.src2 = 32'h0BAD_F00D;
    wait_done(n);
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_hi"}, bus.hi, eh);
    chk({tag, "_lo"}, bus.lo, el);
    chk({tag, "_div0"}, {31'd0, bus.div0}, {31'd0, ed});
  endtask

  initial begin
    int n;
    int seen;
    logic [31:0] ph, pl;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.cancel = 1'b0;
    bus.src1 = '0; bus.src2 = '0; bus.acc_hi = '0; bus.acc_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_div0", {31'd0, bus.div0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0,
        2, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 0, 0,
        2, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
    run("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0,
        33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run("div_pn", OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, 0,
        33, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run("divu", OP_DIVU, 32'd100, 32'd7, 0, 0,
        33, 32'd2, 32'd14, 1'b0);
    run("divz", OP_DIVU, 32'h1234_5678, 32'd0, 0, 0,
        33, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    run("mult_clr", OP_MULT, 32'd7, 32'hFFFF_FFFF, 0, 0,
        2, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0);
    run("minneg1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0,
        33, 32'd0, 32'h8000_0000, 1'b0);

    // Cancel a divide partway through
    ph = bus.hi; pl = bus.lo;
    @(negedge clk);
    bus.op = OP_DIVU; bus.src1 = 32'd1000; bus.src2 = 32'd3;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    chk("cancel_busy", {31'd0, bus.busy}, 32'd0);
    chk("cancel_done", {31'd0, bus.done}, 32'd0);
    chk("cancel_hi", bus.hi, ph);
    chk("cancel_lo", bus.lo, pl);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    chk("cancel_quiet", 32'(seen), 32'd0);
    run("post_cancel", OP_MULT, 32'd3, 32'd4, 0, 0,
        2, 32'd0, 32'd12, 1'b0);

    // Start held high: second op accepted in the DONE cycle
    @(negedge clk);
    bus.op = OP_MULTU; bus.src1 = 32'd5; bus.src2 = 32'd6;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.op = OP_DIVU; bus.src1 = 32'd9; bus.src2 = 32'd2;
    wait_done(n);
    chk("b2b_mul_lat", 32'(n), 32'd2);
    chk("b2b_mul_lo", bus.lo, 32'd30);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_accept", {31'd0, bus.busy}, 32'd1);
    wait_done(n);
    chk("b2b_div_lat", 32'(n), 32'd33);
    chk("b2b_div_lo", bus.lo, 32'd4);
    chk("b2b_div_hi", bus.hi, 32'd1);

`ifdef MULDIV_MADD_EN
    run("madd", OP_MADD, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF,
        2, 32'd1, 32'd0, 1'b0);
    run("msub", OP_MSUB, 32'd1, 32'd1, 32'd0, 32'd0,
        2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
`else
    run("madd", OP_MADD, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF,
        2, 32'd0, 32'd1, 1'b0);
    run("msub", OP_MSUB, 32'd1, 32'd1, 32'd0, 32'd0,
        2, 32'd0, 32'd1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
